// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU request arbiter.
//   DEF_DATA_W : default operand/result width (16)
//   OP_ADD..OP_SAR : ALU opcodes 0..7 as seen on op0/op1/alu_op
// Configuration macro: ALU_ARB_RR_EN (round-robin arbitration when defined).
package alu_pkg;

  localparam int DEF_DATA_W = 16;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_DIR  = 3'd6;
  localparam logic [2:0] OP_SAR  = 3'd7;

endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: two-input grant picker for the shared ALU.
// Ports:
//   req0, req1  : pending requests
//   last_grant  : index of the most recently granted requester
//   enable      : granting is permitted this cycle
//   gnt0, gnt1  : one-hot (or zero) grant, purely combinational
// Configuration macro: ALU_ARB_RR_EN
//   defined   -> on a tie, the requester that was not granted last wins
//   undefined -> requester 0 always wins; last_grant is ignored
module alu_arb_pick
  import alu_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  input  logic enable,
  output logic gnt0,
  output logic gnt1
);

`ifndef ALU_ARB_RR_EN
  // Fixed priority never looks at the grant history.
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;
`endif

  // Pick at most one requester when granting is enabled.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (enable) begin
`ifdef ALU_ARB_RR_EN
      if (req0 && req1) begin
        // last_grant==1 means requester 1 went last, so requester 0 goes now.
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
`else
      gnt0 = req0;
      gnt1 = req1 & ~req0;
`endif
    end else begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters
// and holds each result in a one-entry response register with backpressure.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req0/op0/a0/b0      : requester 0 operation (held until granted)
//   req1/op1/a1/b1      : requester 1 operation (held until granted)
//   gnt0, gnt1          : combinational grant pulse, operands consumed that cycle
//   alu_a/alu_b/alu_op  : operands/opcode driven to the external ALU
//   alu_out             : combinational ALU result
//   rsp_valid/rsp_id/rsp_data/rsp_z : registered result, owner and zero flag
//   rsp_ready           : consumer accepts the held result this cycle
// Configuration macro: ALU_ARB_RR_EN (round-robin instead of fixed priority).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [2:0]        op0,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic              req1,
  input  logic [2:0]        op1,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_z,
  input  logic              rsp_ready
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  logic [0:0]        state_r;
  logic              rsp_id_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              rsp_z_r;
  logic              enable_s;
  logic              last_grant_s;
  logic              any_gnt_s;

  // A new grant is only possible when the response slot is free or being
  // drained this cycle; reset blocks grants so a held result is simply dropped.
  assign enable_s  = ~rst & ((state_r == ST_IDLE) | rsp_ready);
  assign any_gnt_s = gnt0 | gnt1;

  alu_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_s),
    .enable     (enable_s),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

`ifdef ALU_ARB_RR_EN
  logic last_grant_r;

  // Remember who was granted most recently; starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (any_gnt_s) begin
      last_grant_r <= gnt1;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign last_grant_s = last_grant_r;
`else
  assign last_grant_s = 1'b0;
`endif

  // Operand mux toward the shared ALU; idle cycles present a harmless DIR of zero.
  always_comb begin
    alu_op = OP_DIR;
    alu_a  = {DATA_W{1'b0}};
    alu_b  = {DATA_W{1'b0}};
    if (gnt0) begin
      alu_op = op0;
      alu_a  = a0;
      alu_b  = b0;
    end else if (gnt1) begin
      alu_op = op1;
      alu_a  = a1;
      alu_b  = b1;
    end else begin
      alu_op = OP_DIR;
      alu_a  = {DATA_W{1'b0}};
      alu_b  = {DATA_W{1'b0}};
    end
  end

  // Response FSM: capture the ALU result on a grant, hold it under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rsp_id_r   <= 1'b0;
      rsp_data_r <= {DATA_W{1'b0}};
      rsp_z_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_gnt_s) begin
            state_r    <= ST_RESP;
            rsp_id_r   <= gnt1;
            rsp_data_r <= alu_out;
            rsp_z_r    <= (alu_out == {DATA_W{1'b0}});
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (any_gnt_s) begin
            // Consumer took the old result and a new one replaces it (back-to-back).
            state_r    <= ST_RESP;
            rsp_id_r   <= gnt1;
            rsp_data_r <= alu_out;
            rsp_z_r    <= (alu_out == {DATA_W{1'b0}});
          end else if (rsp_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = (state_r == ST_RESP);
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_z     = rsp_z_r;

endmodule
